// File: rtl/div_share_arbiter_if.sv
// Request, divider and response channels of the shared-divider arbiter.
// The arbiter uses the slave modport; requesters, divider and consumer use master.
interface div_share_arbiter_if #(
    parameter int N   = 4,
    parameter int IDW = 2,
    parameter int W   = 32
);
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;

    logic           div_start;
    logic [W-1:0]   div_a;
    logic [W-1:0]   div_b;
    logic           div_done;
    logic [W-1:0]   div_quotient;
    logic [W-1:0]   div_remainder;

    logic           rsp_valid;
    logic           rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_quotient;
    logic [W-1:0]   rsp_remainder;
    logic           rsp_error;
    logic           rsp_timeout;

    logic           busy;

    modport slave (
        input  req_valid, req_a, req_b,
        input  div_done, div_quotient, div_remainder,
        input  rsp_ready,
        output req_ready,
        output div_start, div_a, div_b,
        output rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_error, rsp_timeout,
        output busy
    );

    modport master (
        output req_valid, req_a, req_b,
        output div_done, div_quotient, div_remainder,
        output rsp_ready,
        input  req_ready,
        input  div_start, div_a, div_b,
        input  rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_error, rsp_timeout,
        input  busy
    );
endinterface

// File: rtl/div_share_arbiter.sv
// Round-robin sharing of one start/done unsigned divider among N requesters,
// with local divide-by-zero handling and a hung-divider timeout.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | no operation; grant offered to first valid from rr_ptr
// S_ISSUE   | div_start pulse, timer cleared
// S_WAIT    | waiting for div_done or timer terminal count
// S_RESPOND | rsp_valid held until rsp_ready
module div_share_arbiter #(
    parameter int N       = 4,
    parameter int IDW     = 2,
    parameter int W       = 32,
    parameter int TIMEOUT = 64
) (
    input logic                clk,
    input logic                reset,
    div_share_arbiter_if.slave bus_if
);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESPOND
    } state_t;

    state_t          state_q;
    logic [IDW-1:0]  rr_ptr_q;
    logic [IDW-1:0]  rr_ptr_d;
    logic [IDW-1:0]  id_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    quo_q;
    logic [W-1:0]    rem_q;
    logic            err_q;
    logic            tmo_q;
    logic            start_q;
    logic            rsp_valid_q;
    logic [TW-1:0]   timer_q;

    logic [IDW-1:0]  grant;
    logic            grant_vld;
    logic            xfer;
    logic [W-1:0]    a_sel;
    logic [W-1:0]    b_sel;
    logic [N-1:0]    ready;

    // Cyclic search from rr_ptr: walk backwards so the closest valid wins.
    always_comb begin
        int             idx;
        logic [IDW-1:0] idx_l;
        grant     = '0;
        grant_vld = 1'b0;
        idx       = 0;
        idx_l     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_l = IDW'(idx);
            if (bus_if.req_valid[idx_l]) begin
                grant     = idx_l;
                grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (IDW'(i) == grant) begin
                a_sel = bus_if.req_a[i*W +: W];
                b_sel = bus_if.req_b[i*W +: W];
            end
        end
    end

    always_comb begin
        if (int'(grant) + 1 >= N) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = grant + 1'b1;
        end
    end

    // Reset is folded in so req_ready reads zero while reset is held.
    assign xfer = (state_q == S_IDLE) && grant_vld && !reset;

    always_comb begin
        ready = '0;
        if (xfer) begin
            ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            err_q       <= 1'b0;
            tmo_q       <= 1'b0;
            start_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            timer_q     <= '0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (xfer) begin
                        a_q      <= a_sel;
                        b_q      <= b_sel;
                        id_q     <= grant;
                        rr_ptr_q <= rr_ptr_d;
                        if (b_sel == '0) begin
                            quo_q       <= '1;
                            rem_q       <= a_sel;
                            err_q       <= 1'b1;
                            tmo_q       <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RESPOND;
                        end else begin
                            start_q <= 1'b1;
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    timer_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    timer_q <= timer_q + 1'b1;
                    // A done arriving on the terminal-count cycle still wins.
                    if (bus_if.div_done) begin
                        quo_q       <= bus_if.div_quotient;
                        rem_q       <= bus_if.div_remainder;
                        err_q       <= 1'b0;
                        tmo_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESPOND;
                    end else if (timer_q == TIMER_LAST) begin
                        quo_q       <= '0;
                        rem_q       <= '0;
                        err_q       <= 1'b1;
                        tmo_q       <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    if (bus_if.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus_if.req_ready     = ready;
    assign bus_if.div_start     = start_q;
    assign bus_if.div_a         = a_q;
    assign bus_if.div_b         = b_q;
    assign bus_if.rsp_valid     = rsp_valid_q;
    assign bus_if.rsp_id        = id_q;
    assign bus_if.rsp_quotient  = quo_q;
    assign bus_if.rsp_remainder = rem_q;
    assign bus_if.rsp_error     = err_q;
    assign bus_if.rsp_timeout   = tmo_q;
    assign bus_if.busy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_div_share_arbiter.sv
// Scoreboard bench for div_share_arbiter: requester stimulus, a behavioural
// divider, a round-robin grant model and an in-order response checker.
module tb_div_share_arbiter;
    localparam int N       = 4;
    localparam int IDW     = 2;
    localparam int W       = 32;
    localparam int TIMEOUT = 64;

    typedef struct {
        logic [IDW-1:0] id;
        logic [W-1:0]   q;
        logic [W-1:0]   r;
        logic           err;
        logic           tmo;
        int             cyc;
    } exp_t;

    logic clk;
    logic reset;

    div_share_arbiter_if #(.N(N), .IDW(IDW), .W(W)) bus_if ();

    div_share_arbiter #(.N(N), .IDW(IDW), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_if (bus_if)
    );

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          acc_cyc = 0;
    int          hs_cyc = 0;
    int          n_starts = 0;
    int          viol = 0;
    int          stab_err = 0;
    int          div_lat = 10;
    bit          hang = 0;
    logic [W-1:0] a_arr [N];
    logic [W-1:0] b_arr [N];
    exp_t        sb [$];
    int          grant_log [$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Behavioural divider: done pulse div_lat cycles after the start cycle.
    initial begin
        logic [W-1:0] pa, pb;
        int  cnt;
        bit  pending;
        pending = 0;
        cnt = 0;
        pa = '0;
        pb = '0;
        bus_if.div_done      = 1'b0;
        bus_if.div_quotient  = '0;
        bus_if.div_remainder = '0;
        forever begin
            @(negedge clk);
            bus_if.div_done = 1'b0;
            if (reset) begin
                pending = 0;
            end else begin
                if (pending) begin
                    if (bus_if.div_a !== pa || bus_if.div_b !== pb) stab_err++;
                    cnt--;
                    if (cnt == 0) begin
                        pending = 0;
                        bus_if.div_done      = 1'b1;
                        bus_if.div_quotient  = pa / pb;
                        bus_if.div_remainder = pa % pb;
                    end
                end
                if (bus_if.div_start) begin
                    n_starts++;
                    if (!hang) begin
                        pending = 1;
                        cnt = div_lat;
                        pa = bus_if.div_a;
                        pb = bus_if.div_b;
                    end
                end
            end
        end
    end

    // Grant model, scoreboard push on accept, response compare and pop.
    initial begin
        int   rr_m, g, j;
        bit   found, rsp_seen, prev_rdy;
        exp_t e;
        logic [W*2+IDW+1:0] cur, snap;
        rr_m = 0;
        rsp_seen = 0;
        prev_rdy = 0;
        snap = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                rr_m = 0;
                rsp_seen = 0;
                prev_rdy = 0;
            end else begin
                if (|bus_if.req_ready || (!bus_if.busy && |bus_if.req_valid)) begin
                    g = 0;
                    found = 0;
                    for (int k = 0; k < N; k++) begin
                        j = (rr_m + k) % N;
                        if (!found && bus_if.req_valid[j]) begin
                            g = j;
                            found = 1;
                        end
                    end
                    chk("grant", bus_if.req_ready, found ? (4'b0001 << g) : 4'b0000);
                    if (found && bus_if.req_ready[g]) begin
                        e.id = IDW'(g);
                        if (b_arr[g] == '0) begin
                            e.q = '1; e.r = a_arr[g]; e.err = 1; e.tmo = 0; e.cyc = cyc + 1;
                        end else if (hang) begin
                            e.q = '0; e.r = '0; e.err = 1; e.tmo = 1; e.cyc = cyc + 2 + TIMEOUT;
                        end else begin
                            e.q = a_arr[g] / b_arr[g]; e.r = a_arr[g] % b_arr[g];
                            e.err = 0; e.tmo = 0; e.cyc = cyc + 2 + div_lat;
                        end
                        sb.push_back(e);
                        grant_log.push_back(g);
                        rr_m = (g + 1) % N;
                        acc_cnt++;
                        acc_cyc = cyc;
                    end
                end
                if (prev_rdy && |bus_if.req_ready) viol++;
                if (|bus_if.req_ready && bus_if.rsp_valid) viol++;
                prev_rdy = |bus_if.req_ready;

                if (bus_if.rsp_valid) begin
                    cur = {bus_if.rsp_id, bus_if.rsp_quotient, bus_if.rsp_remainder,
                           bus_if.rsp_error, bus_if.rsp_timeout};
                    if (!rsp_seen) begin
                        if (sb.size() == 0) begin
                            chk("unexp_rsp", bus_if.rsp_valid, 1'b0);
                        end else begin
                            e = sb[0];
                            chk("rsp", cur, {e.id, e.q, e.r, e.err, e.tmo});
                            chk("rsp_cyc", cyc, e.cyc);
                        end
                        snap = cur;
                        rsp_seen = 1;
                    end else begin
                        chk("rsp_hold", cur, snap);
                    end
                    if (bus_if.rsp_ready) begin
                        if (sb.size() != 0) void'(sb.pop_front());
                        rsp_seen = 0;
                        hs_cyc = cyc;
                    end
                end else begin
                    rsp_seen = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {bus_if.req_ready, bus_if.div_start, bus_if.rsp_valid, bus_if.rsp_id,
                            bus_if.rsp_error, bus_if.rsp_timeout, bus_if.busy}, '0);
        chk({tag, "_div"}, {bus_if.div_a, bus_if.div_b}, '0);
        chk({tag, "_rsp"}, {bus_if.rsp_quotient, bus_if.rsp_remainder}, '0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #2;
        chk_zero("rst");
        sb.delete();
        tick();
        tick();
        reset = 1'b0;
        grant_log.delete();
        tick();
    endtask

    task automatic set_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        a_arr[id] = a;
        b_arr[id] = b;
        bus_if.req_a[id*W +: W] = a;
        bus_if.req_b[id*W +: W] = b;
    endtask

    task automatic do_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        int c0, n;
        c0 = acc_cnt;
        n = 0;
        set_op(id, a, b);
        bus_if.req_valid[id] = 1'b1;
        while (acc_cnt == c0 && n < 200) begin
            tick();
            n++;
        end
        chk("accept", acc_cnt - c0, 1);
        bus_if.req_valid[id] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus_if.rsp_valid) && n < 400) begin
            tick();
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        int s0, c0, n, low;
        reset = 1'b0;
        bus_if.req_valid = '0;
        bus_if.req_a     = '0;
        bus_if.req_b     = '0;
        bus_if.rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
        end
        #1;
        apply_reset();

        // single request, 33-cycle divider
        div_lat = 33;
        s0 = n_starts;
        do_req(0, 100, 7);
        low = 0;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            if (sb.size() != 0 && !bus_if.busy) low++;
            n++;
        end
        tick();
        wait_idle();
        chk("busy_hold", low, 0);
        chk("one_start", n_starts - s0, 1);

        // divide by zero
        s0 = n_starts;
        do_req(2, 32'hDEADBEEF, 0);
        wait_idle();
        chk("dz_no_start", n_starts - s0, 0);

        // round robin from rr_ptr=0, all four held valid
        apply_reset();
        div_lat = 3;
        for (int i = 0; i < N; i++) set_op(i, 32'd1000 * (i + 1) + i, i + 3);
        c0 = acc_cnt;
        n = 0;
        bus_if.req_valid = '1;
        while (acc_cnt < c0 + 5 && n < 300) begin
            tick();
            n++;
        end
        bus_if.req_valid = '0;
        chk("rr_cnt", acc_cnt - c0, 5);
        for (int k = 0; k < 5; k++) begin
            chk("rr_order", (k < grant_log.size()) ? grant_log[k] : -1, k % N);
        end
        wait_idle();

        // backpressure for 10 cycles with a competing requester
        div_lat = 5;
        bus_if.rsp_ready = 1'b0;
        do_req(1, 1000, 33);
        set_op(3, 77, 0);
        bus_if.req_valid[3] = 1'b1;
        n = 0;
        while (!bus_if.rsp_valid && n < 100) begin
            tick();
            n++;
        end
        repeat (10) tick();
        c0 = acc_cnt;
        bus_if.rsp_ready = 1'b1;
        n = 0;
        while (acc_cnt == c0 && n < 50) begin
            tick();
            n++;
        end
        bus_if.req_valid[3] = 1'b0;
        chk("bp_grant_gap", acc_cyc - hs_cyc, 1);
        wait_idle();

        // hung divider, then a normal request
        hang = 1;
        s0 = n_starts;
        do_req(0, 5, 1);
        wait_idle();
        hang = 0;
        chk("tmo_start", n_starts - s0, 1);
        div_lat = 7;
        do_req(1, 81, 9);
        wait_idle();

        // done on the terminal-count cycle beats the timeout
        div_lat = TIMEOUT;
        do_req(2, 32'hFFFF_FFFF, 16);
        wait_idle();

        // reset mid-WAIT drops the operation and rewinds rr_ptr
        div_lat = 100;
        s0 = n_starts;
        do_req(1, 50, 5);
        n = 0;
        while (n_starts == s0 && n < 20) begin
            tick();
            n++;
        end
        repeat (5) tick();
        reset = 1'b1;
        #1;
        chk_zero("rst_wait");
        sb.delete();
        tick();
        tick();
        reset = 1'b0;
        grant_log.delete();
        repeat (20) tick();
        chk("rst_no_rsp", bus_if.rsp_valid, 1'b0);
        div_lat = 4;
        set_op(1, 9, 2);
        set_op(3, 40, 6);
        c0 = acc_cnt;
        bus_if.req_valid[1] = 1'b1;
        bus_if.req_valid[3] = 1'b1;
        n = 0;
        while (acc_cnt == c0 && n < 50) begin
            tick();
            n++;
        end
        bus_if.req_valid = '0;
        chk("post_rst_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 1);
        wait_idle();

        chk("protocol_viol", viol, 0);
        chk("div_operand_stab", stab_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
